// File: rtl/ddr_pkg.sv
// Shared types and encodings for the DDR write-capture path.
// Defining DDR_WR_PARITY_EN adds a parity-mismatch flag, which widens err to 3 bits.
package ddr_pkg;

    localparam int CAP_W = 64;
    typedef logic [CAP_W-1:0] cap_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PRE,
        ST_PRE,
        ST_BURST,
        ST_POST
    } wr_state_e;

    typedef enum logic [1:0] {
        PRE_1CK = 2'd1,
        PRE_2CK = 2'd2
    } preamble_e;

    typedef enum logic [3:0] {
        BL_BC4 = 4'd4,
        BL_BL8 = 4'd8
    } burst_len_e;

    localparam int ERR_TMO = 0;
    localparam int ERR_STB = 1;
`ifdef DDR_WR_PARITY_EN
    localparam int ERR_PAR = 2;
    localparam int ERR_W   = 3;
`else
    localparam int ERR_W   = 2;
`endif

    // Any burst_length other than BC4 is captured as a full BL8 burst.
    function automatic logic [3:0] bl_beats(input logic [3:0] bl);
        return (bl == BL_BC4) ? 4'd4 : 4'd8;
    endfunction

    function automatic logic pre_is_2ck(input logic [1:0] pre);
        return pre == PRE_2CK;
    endfunction

endpackage

// File: rtl/ctrl_dqs_edge_det.sv
// Registers the differential write strobe and flags beat toggles, preamble start
// and invalid (non-differential) strobe levels.
module ctrl_dqs_edge_det (
    input  logic CK_t,
    input  logic reset_n,
    input  logic dqs_t,
    input  logic dqs_c,
    output logic beat_stb,
    output logic strobe_err,
    output logic pre_det
);

    logic dqs_t_q;
    logic dqs_c_q;

    // Reset to the preamble level so the first burst cycle sees a clean toggle.
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            dqs_t_q <= 1'b0;
            dqs_c_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            dqs_t_q <= dqs_t;
            dqs_c_q <= dqs_c;
        end
    end

    // A valid beat needs both legs to flip; a one-legged flip already shows up as strobe_err.
    assign beat_stb   = (dqs_t_q ^ dqs_t) & (dqs_c_q ^ dqs_c);
    assign strobe_err = ~(dqs_t ^ dqs_c);
    assign pre_det    = ~dqs_t & dqs_c;

endmodule

// File: rtl/ctrl_wr_capture.sv
// Captures one DDR write burst (BC4/BL8) beat by beat into a wide word.
// Optional DDR_WR_PARITY_EN: an extra XOR-parity beat follows the data beats.
module ctrl_wr_capture
    import ddr_pkg::*;
#(
    parameter int DQ_W       = 8,
    parameter int MAX_BEATS  = 8,
    parameter int WR_TIMEOUT = 16
) (
    input  logic                      CK_t,
    input  logic                      reset_n,
    input  logic                      wr_start,
    input  logic [1:0]                preamble,
    input  logic [3:0]                burst_length,
    input  logic                      dqs_t,
    input  logic                      dqs_c,
    input  logic [DQ_W-1:0]           dq,
    output logic [DQ_W*MAX_BEATS-1:0] wr_data,
    output logic                      wr_data_valid,
    output logic                      busy,
    output logic [ERR_W-1:0]          err
);

    localparam int WORD_W = DQ_W * MAX_BEATS;
    localparam int TMO_W  = $clog2(WR_TIMEOUT + 1);

    wr_state_e         state_q, state_d;
    logic              pre2_q;
    logic              pre_cnt_q;
    logic [3:0]        n_beats_q;
    logic [3:0]        beat_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic [WORD_W-1:0] cap_q;

    logic beat_stb, strobe_err, pre_det;
    logic start_acc, capture, commit, set_tmo, set_stb;
`ifdef DDR_WR_PARITY_EN
    logic [DQ_W-1:0] par_acc_q;
    logic            set_par;
`endif

    ctrl_dqs_edge_det u_edge_det (
        .CK_t       (CK_t),
        .reset_n    (reset_n),
        .dqs_t      (dqs_t),
        .dqs_c      (dqs_c),
        .beat_stb   (beat_stb),
        .strobe_err (strobe_err),
        .pre_det    (pre_det)
    );

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        // NOTE: every signal driven here is defaulted first so no path infers a latch.
        state_d   = state_q;
        start_acc = 1'b0;
        capture   = 1'b0;
        commit    = 1'b0;
        set_tmo   = 1'b0;
        set_stb   = 1'b0;
`ifdef DDR_WR_PARITY_EN
        set_par   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (wr_start) begin
                    start_acc = 1'b1;
                    state_d   = ST_WAIT_PRE;
                end
            end
            ST_WAIT_PRE: begin
                if (pre_det) begin
                    state_d = ST_PRE;
                end else if (tmo_cnt_q == TMO_W'(WR_TIMEOUT - 1)) begin
                    set_tmo = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (strobe_err) begin
                    set_stb = 1'b1;
                    state_d = ST_IDLE;
                end else if (pre_cnt_q == pre2_q) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (strobe_err) begin
                    set_stb = 1'b1;
                    state_d = ST_IDLE;
                end else if (beat_stb) begin
`ifdef DDR_WR_PARITY_EN
                    if (beat_cnt_q == n_beats_q) begin
                        if (dq != par_acc_q) begin
                            set_par = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_POST;
                        end
                    end else begin
                        capture = 1'b1;
                    end
`else
                    capture = 1'b1;
                    if (beat_cnt_q == n_beats_q - 4'd1) state_d = ST_POST;
`endif
                end
            end
            ST_POST: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            pre2_q        <= 1'b0;
            pre_cnt_q     <= 1'b0;
            n_beats_q     <= 4'd0;
            beat_cnt_q    <= 4'd0;
            tmo_cnt_q     <= '0;
            cap_q         <= '0;
            wr_data       <= '0;
            wr_data_valid <= 1'b0;
            err           <= '0;
`ifdef DDR_WR_PARITY_EN
            par_acc_q     <= '0;
`endif
        end else begin
            wr_data_valid <= 1'b0;
            // Second PRE cycle is marked by having been in PRE on the previous edge.
            pre_cnt_q     <= (state_q == ST_PRE);

            if (start_acc) begin
                pre2_q     <= pre_is_2ck(preamble);
                n_beats_q  <= bl_beats(burst_length);
                beat_cnt_q <= 4'd0;
                tmo_cnt_q  <= '0;
                cap_q      <= '0;
                err        <= '0;
`ifdef DDR_WR_PARITY_EN
                par_acc_q  <= '0;
`endif
            end

            if (state_q == ST_WAIT_PRE) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);

            if (capture) begin
                cap_q[int'(beat_cnt_q)*DQ_W +: DQ_W] <= dq;
                beat_cnt_q <= beat_cnt_q + 4'd1;
`ifdef DDR_WR_PARITY_EN
                par_acc_q  <= par_acc_q ^ dq;
`endif
            end

            if (set_tmo) err[ERR_TMO] <= 1'b1;
            if (set_stb) err[ERR_STB] <= 1'b1;
`ifdef DDR_WR_PARITY_EN
            if (set_par) err[ERR_PAR] <= 1'b1;
`endif

            // wr_data only changes on a completed burst; aborts leave it untouched.
            if (commit) begin
                wr_data       <= cap_q;
                wr_data_valid <= 1'b1;
            end
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule
